// File: rtl/lcd_scanout_dma.sv
// Framebuffer scanout: burst-reads packed 8-bit pixels from SDRAM into a word FIFO
// and streams them one byte per cycle to the LCD stage over valid/ready.
module lcd_scanout_dma #(
  parameter int unsigned READ_BURST_LENGTH = 8,
  parameter int unsigned FB_WORDS          = 96000,
  parameter int unsigned FIFO_DEPTH        = 64
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  output logic        o_SDRAM_Request,
  input  logic        i_SDRAM_Yield,
  output logic [1:0]  o_Command,
  output logic [21:0] o_Data_Address,
  input  logic        i_Data_Read_Valid,
  input  logic [31:0] i_Data_Read,
  input  logic        i_Frame_Sync,
  output logic        o_Px_Valid,
  input  logic        i_Px_Ready,
  output logic [7:0]  o_Px_Data,
  output logic        o_Frame_Start,
  output logic        o_Underflow
);

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b01;

  localparam int unsigned AW       = 22;
  localparam int unsigned SW       = AW + 1;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned HW       = CNT_W + 1;
  localparam int unsigned BEAT_W   = (READ_BURST_LENGTH > 1) ? $clog2(READ_BURST_LENGTH) : 1;
  localparam int unsigned PX_TOTAL = FB_WORDS * 4;
  localparam int unsigned PX_W     = $clog2(PX_TOTAL);
  localparam int unsigned ROOM_MAX = FIFO_DEPTH - READ_BURST_LENGTH;

  typedef enum logic [1:0] {IDLE, REQUEST, READ, DRAIN} state_t;

  state_t              state, state_d;
  logic                req_q, req_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       fetch_q, fetch_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                fifo_wr;

  logic [31:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [31:0]         unp_word;
  logic [1:0]          byte_idx;
  logic                unp_valid;
  logic [PX_W-1:0]     px_cnt;
  logic                underflow_q;

  logic [HW-1:0]       held;
  logic                room;
  logic [SW-1:0]       fetch_sum;
  logic [AW-1:0]       fetch_wrap;
  logic                last_beat;
  logic                accept;
  logic                pop;

  // The word parked in the unpacker counts against capacity, so a full
  // pipeline holds exactly FIFO_DEPTH words.
  assign held       = HW'(fifo_cnt) + HW'(unp_valid);
  assign room       = held <= HW'(ROOM_MAX);
  assign fetch_sum  = SW'(fetch_q) + SW'(READ_BURST_LENGTH);
  assign fetch_wrap = (fetch_sum >= SW'(FB_WORDS)) ? '0 : fetch_sum[AW-1:0];
  assign last_beat  = (beat_q == '0);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      cmd_q   <= CMD_IDLE;
      addr_q  <= '0;
      fetch_q <= '0;
      beat_q  <= '0;
    end else begin
      state   <= state_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      fetch_q <= fetch_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state;
    req_d   = req_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    fetch_d = fetch_q;
    beat_d  = beat_q;
    fifo_wr = 1'b0;
    case (state)
      IDLE: begin
        cmd_d = CMD_IDLE;
        if (room && !i_Frame_Sync) begin
          state_d = REQUEST;
          req_d   = 1'b1;
        end
      end
      REQUEST: begin
        if (i_SDRAM_Yield) begin
          state_d = READ;
          cmd_d   = CMD_READ;
          beat_d  = BEAT_W'(READ_BURST_LENGTH - 1);
          addr_d  = i_Frame_Sync ? '0 : fetch_q;
        end
      end
      READ, DRAIN: begin
        if (i_Data_Read_Valid) begin
          fifo_wr = (state == READ) && !i_Frame_Sync;
          addr_d  = addr_q + 1'b1;
          beat_d  = beat_q - 1'b1;
          if (last_beat) begin
            if (state == READ) fetch_d = fetch_wrap;
            state_d = IDLE;
            req_d   = 1'b0;
            cmd_d   = CMD_IDLE;
          end
        end
        if (state == READ && i_Frame_Sync && !(i_Data_Read_Valid && last_beat))
          state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
    if (i_Frame_Sync) fetch_d = '0;
  end

  assign accept = unp_valid && i_Px_Ready;
  assign pop    = (fifo_cnt != '0) && (!unp_valid || (accept && byte_idx == 2'd3));

  always_ff @(posedge i_Clk) begin
    if (fifo_wr) mem[wr_ptr] <= i_Data_Read;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Frame_Sync) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      unp_valid <= 1'b0;
      byte_idx  <= '0;
      px_cnt    <= '0;
      if (i_Reset) unp_word <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(pop);
      if (pop) begin
        unp_word  <= mem[rd_ptr];
        byte_idx  <= '0;
        unp_valid <= 1'b1;
      end else if (accept) begin
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) unp_valid <= 1'b0;
      end
      if (accept) px_cnt <= (px_cnt == PX_W'(PX_TOTAL - 1)) ? '0 : px_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) underflow_q <= 1'b0;
    else         underflow_q <= i_Px_Ready && !unp_valid;
  end

  assign o_SDRAM_Request = req_q;
  assign o_Command       = cmd_q;
  assign o_Data_Address  = addr_q;
  assign o_Px_Valid      = unp_valid;
  assign o_Px_Data       = unp_word[{byte_idx, 3'b000} +: 8];
  assign o_Frame_Start   = unp_valid && (px_cnt == '0);
  assign o_Underflow     = underflow_q;

endmodule
